// File: rtl/ray_dir_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ray_dir_gen_pkg
// Brief    : Shared types for the camera ray-direction generator.
// Revision : 1.0 - initial release
// ============================================================================
package ray_dir_gen_pkg;

    localparam logic [31:0] FP_ONE = 32'h0001_0000;

    // Q16.16 direction vector; x occupies the most significant word.
    typedef struct packed {
        logic signed [31:0] x;
        logic signed [31:0] y;
        logic signed [31:0] z;
    } vec3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rdg_state_t;

endpackage
`default_nettype wire

// File: rtl/ray_dir_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : ray_dir_gen_if
// Brief    : Frame control, configuration and ray output bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface ray_dir_gen_if
    import ray_dir_gen_pkg::*;
#(
    parameter int H_RES = 64,
    parameter int V_RES = 48
);
    logic                       start;
    logic                       stall;
    logic [31:0]                cfg_x_start;
    logic [31:0]                cfg_y_start;
    logic [31:0]                cfg_du;
    logic [31:0]                cfg_dv;
    logic [31:0]                cfg_z;
    vec3                        ray_dir;
    logic                       ray_valid;
    logic [$clog2(H_RES)-1:0]   pix_x;
    logic [$clog2(V_RES)-1:0]   pix_y;
    logic                       busy;
    logic                       frame_done;

    modport master (
        output start, stall, cfg_x_start, cfg_y_start, cfg_du, cfg_dv, cfg_z,
        input  ray_dir, ray_valid, pix_x, pix_y, busy, frame_done
    );

    modport slave (
        input  start, stall, cfg_x_start, cfg_y_start, cfg_du, cfg_dv, cfg_z,
        output ray_dir, ray_valid, pix_x, pix_y, busy, frame_done
    );

endinterface
`default_nettype wire

// File: rtl/ray_dir_gen_raster_counter.sv
`default_nettype none
// ============================================================================
// Module   : raster_counter
// Brief    : Column/row raster counter with row and frame end flags.
// Revision : 1.0 - initial release
// ============================================================================
module raster_counter #(
    parameter int H_RES = 64,
    parameter int V_RES = 48
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       i_clr,
    input  wire logic                       i_en,
    output logic [$clog2(H_RES)-1:0]        o_cx,
    output logic [$clog2(V_RES)-1:0]        o_cy,
    output logic                            o_end_of_row,
    output logic                            o_end_of_frame
);
    localparam int c_xw = $clog2(H_RES);
    localparam int c_yw = $clog2(V_RES);

    logic [c_xw-1:0] r_cx;
    logic [c_yw-1:0] r_cy;
    logic            w_end_of_row;
    logic            w_end_of_frame;

    assign w_end_of_row   = (r_cx == c_xw'(H_RES - 1));
    assign w_end_of_frame = w_end_of_row && (r_cy == c_yw'(V_RES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (i_clr) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (i_en) begin
            if (w_end_of_row) begin
                r_cx <= '0;
                // Rows wrap after the last one so the count never leaves range.
                r_cy <= w_end_of_frame ? '0 : r_cy + 1'b1;
            end else begin
                r_cx <= r_cx + 1'b1;
            end
        end
    end

    assign o_cx           = r_cx;
    assign o_cy           = r_cy;
    assign o_end_of_row   = w_end_of_row;
    assign o_end_of_frame = w_end_of_frame;

endmodule
`default_nettype wire

// File: rtl/ray_dir_gen.sv
`default_nettype none
// ============================================================================
// Module   : ray_dir_gen
// Brief    : Raster-order camera ray generator built from add/sub steps.
// Revision : 1.0 - initial release
// ============================================================================
module ray_dir_gen
    import ray_dir_gen_pkg::*;
#(
    parameter int H_RES = 64,
    parameter int V_RES = 48
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    ray_dir_gen_if.slave    bus
);
    localparam int c_xw = $clog2(H_RES);
    localparam int c_yw = $clog2(V_RES);

    rdg_state_t      r_state;
    rdg_state_t      w_next_state;
    logic            w_load;
    logic            w_step;
    logic            w_drain_exit;

    logic [31:0]     r_x_start;
    logic [31:0]     r_du;
    logic [31:0]     r_dv;
    logic [31:0]     r_z;
    logic [31:0]     r_x_acc;
    logic [31:0]     r_y_acc;

    vec3             r_ray_dir;
    logic            r_ray_valid;
    logic [c_xw-1:0] r_pix_x;
    logic [c_yw-1:0] r_pix_y;
    logic            r_frame_done;

    logic [c_xw-1:0] w_cx;
    logic [c_yw-1:0] w_cy;
    logic            w_end_of_row;
    logic            w_end_of_frame;

    raster_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_raster (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_clr          (w_load),
        .i_en           (w_step),
        .o_cx           (w_cx),
        .o_cy           (w_cy),
        .o_end_of_row   (w_end_of_row),
        .o_end_of_frame (w_end_of_frame)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_drain_exit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.stall) begin
                    w_step = 1'b1;
                    if (w_end_of_frame) begin
                        w_next_state = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!bus.stall) begin
                    w_drain_exit = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_start    <= '0;
            r_du         <= '0;
            r_dv         <= '0;
            r_z          <= '0;
            r_x_acc      <= '0;
            r_y_acc      <= '0;
            r_ray_dir    <= '0;
            r_ray_valid  <= 1'b0;
            r_pix_x      <= '0;
            r_pix_y      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            // Pulse lasts one edge only; stall has no say over it.
            r_frame_done <= w_drain_exit;
            if (w_load) begin
                r_x_start <= bus.cfg_x_start;
                r_du      <= bus.cfg_du;
                r_dv      <= bus.cfg_dv;
                r_z       <= bus.cfg_z;
                r_x_acc   <= bus.cfg_x_start;
                r_y_acc   <= bus.cfg_y_start;
            end
            if (w_step) begin
                r_ray_dir   <= {r_x_acc, r_y_acc, r_z};
                r_pix_x     <= w_cx;
                r_pix_y     <= w_cy;
                r_ray_valid <= 1'b1;
                if (w_end_of_row) begin
                    r_x_acc <= r_x_start;
                    r_y_acc <= r_y_acc - r_dv;
                end else begin
                    r_x_acc <= r_x_acc + r_du;
                end
            end
            if (w_drain_exit) begin
                r_ray_valid <= 1'b0;
            end
        end
    end

    assign bus.ray_dir    = r_ray_dir;
    assign bus.ray_valid  = r_ray_valid;
    assign bus.pix_x      = r_pix_x;
    assign bus.pix_y      = r_pix_y;
    assign bus.frame_done = r_frame_done;
    assign bus.busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire
